// File: rtl/s_cell_bank_pkg.sv
// Shared definitions for the S-cell bank: config bit layout, select codes
// and the configuration-load state encoding.
package s_cell_pkg;

  localparam int CFG_BITS_PER_LANE = 2;
  localparam int CFG_BYPASS        = 0;
  localparam int CFG_INVERT        = 1;

  localparam logic [1:0] SEL_D00 = 2'b00;
  localparam logic [1:0] SEL_D01 = 2'b01;
  localparam logic [1:0] SEL_D10 = 2'b10;
  localparam logic [1:0] SEL_D11 = 2'b11;

  typedef enum logic [1:0] {
    CFG_UNCONF  = 2'd0,
    CFG_LOADING = 2'd1,
    CFG_READY   = 2'd2
  } cfg_state_t;

  // Shared select decode: OR term drives the upper bit, gated a0 the lower.
  function automatic logic [1:0] sel_code(input logic a1, input logic b1,
                                          input logic a0, input logic s_en);
    return {a1 | b1, a0 & s_en};
  endfunction

endpackage

// File: rtl/s_cell_bank_if.sv
// Signal bundle between the routing stage and the S-cell bank.
// cfg_en is a one-cycle strobe with no backpressure: every cycle it is high,
// exactly one config bit is consumed at the next rising clk.
interface s_cell_bank_if import s_cell_pkg::*; #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] d00;
  logic [WIDTH-1:0] d01;
  logic [WIDTH-1:0] d10;
  logic [WIDTH-1:0] d11;
  logic             a1;
  logic             b1;
  logic             a0;
  logic             s_en;
  logic             ce;
  logic             cfg_en;
  logic             cfg_din;
  logic             cfg_dout;
  logic             cfg_busy;
  logic             cfg_done;
  logic [WIDTH-1:0] q;
  cfg_state_t       cfg_state;

  modport master (
    output d00, d01, d10, d11, a1, b1, a0, s_en, ce, cfg_en, cfg_din,
    input  cfg_dout, cfg_busy, cfg_done, q, cfg_state
  );

  modport slave (
    input  d00, d01, d10, d11, a1, b1, a0, s_en, ce, cfg_en, cfg_din,
    output cfg_dout, cfg_busy, cfg_done, q, cfg_state
  );

endinterface

// File: rtl/s_cell_bank_lane.sv
// One S-cell lane: 4:1 mux, clear-able register with enable, and a
// bypass/invert output stage that is forced low while a config load runs.
module s_cell_lane
  import s_cell_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       d00,
  input  logic       d01,
  input  logic       d10,
  input  logic       d11,
  input  logic [1:0] sel,
  input  logic       ce,
  input  logic       busy,
  input  logic       bypass,
  input  logic       invert,
  output logic       q
);

  logic m;
  logic r;

  always_comb begin
    m = d00;
    case (sel)
      SEL_D00: m = d00;
      SEL_D01: m = d01;
      SEL_D10: m = d10;
      SEL_D11: m = d11;
      default: m = d00;
    endcase
  end

  // The register is frozen for the whole load so the pre-load value survives.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r <= 1'b0;
    end else if (ce && !busy) begin
      r <= m;
    end
  end

  assign q = busy ? 1'b0 : ((bypass ? m : r) ^ invert);

endmodule

// File: rtl/s_cell_bank.sv
// Bank of WIDTH S-cell lanes sharing select terms, plus the serial
// configuration chain and its load counter / state tracking.
module s_cell_bank
  import s_cell_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          clr,
  s_cell_bank_if.slave  bus
);

  localparam int CHAIN = WIDTH * CFG_BITS_PER_LANE;
  localparam int CW    = $clog2(CHAIN + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CHAIN-1:0] cfg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  cfg_state_t       state;
  logic             busy;
  logic             done;
  logic [1:0]       sel;

  // A strobe in READY starts a fresh load rather than saturating.
  always_comb begin
    cnt_nxt = (cnt == CNT_FULL) ? CNT_ONE : cnt + CNT_ONE;
  end

  // busy/done are registered together with cnt so neither has a path from cfg_en.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cfg   <= '0;
      cnt   <= '0;
      state <= CFG_UNCONF;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (bus.cfg_en) begin
      cfg <= {cfg[CHAIN-2:0], bus.cfg_din};
      cnt <= cnt_nxt;
      if (cnt_nxt == CNT_FULL) begin
        state <= CFG_READY;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= CFG_LOADING;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end
  end

  assign sel           = sel_code(bus.a1, bus.b1, bus.a0, bus.s_en);
  assign bus.cfg_dout  = cfg[CHAIN-1];
  assign bus.cfg_busy  = busy;
  assign bus.cfg_done  = done;
  assign bus.cfg_state = state;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    s_cell_lane u_lane (
      .clk    (clk),
      .clr    (clr),
      .d00    (bus.d00[i]),
      .d01    (bus.d01[i]),
      .d10    (bus.d10[i]),
      .d11    (bus.d11[i]),
      .sel    (sel),
      .ce     (bus.ce),
      .busy   (busy),
      .bypass (cfg[CFG_BITS_PER_LANE*i + CFG_BYPASS]),
      .invert (cfg[CFG_BITS_PER_LANE*i + CFG_INVERT]),
      .q      (bus.q[i])
    );
  end

endmodule

// File: tb/tb_s_cell_bank.sv
// Self-checking bench for s_cell_bank (WIDTH=4): directed scenarios followed
// by random traffic, all compared against a bit-level behavioural model.
module tb_s_cell_bank;
  import s_cell_pkg::*;

  localparam int W  = 4;
  localparam int CH = 2 * W;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  s_cell_bank_if #(.WIDTH(W)) bus ();

  s_cell_bank #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: index k of m_cfg is chain bit k; m_cnt counts strobes.
  bit m_cfg[$];
  int m_cnt;
  bit m_r[W];

  function automatic void model_reset();
    m_cfg.delete();
    for (int k = 0; k < CH; k++) m_cfg.push_back(1'b0);
    m_cnt = 0;
    for (int i = 0; i < W; i++) m_r[i] = 1'b0;
  endfunction

  function automatic bit model_busy();
    return (m_cnt > 0) && (m_cnt < CH);
  endfunction

  function automatic bit lane_m(input int i);
    int idx;
    idx = ((bus.a1 || bus.b1) ? 2 : 0) + ((bus.a0 && bus.s_en) ? 1 : 0);
    case (idx)
      0:       return bus.d00[i];
      1:       return bus.d01[i];
      2:       return bus.d10[i];
      default: return bus.d11[i];
    endcase
  endfunction

  function automatic logic [W-1:0] model_q();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (!model_busy())
        v[i] = (m_cfg[2*i] ? lane_m(i) : m_r[i]) ^ m_cfg[2*i+1];
    end
    return v;
  endfunction

  function automatic void model_edge();
    bit b;
    b = model_busy();
    if (bus.ce && !b)
      for (int i = 0; i < W; i++) m_r[i] = lane_m(i);
    if (bus.cfg_en) begin
      m_cfg.push_front(bus.cfg_din);
      void'(m_cfg.pop_back());
      m_cnt = (m_cnt == CH) ? 1 : m_cnt + 1;
    end
  endfunction

  task automatic check_all(input string pfx);
    check({pfx, "_q"},    bus.q,        model_q());
    check({pfx, "_busy"}, bus.cfg_busy, model_busy());
    check({pfx, "_done"}, bus.cfg_done, m_cnt == CH);
    check({pfx, "_dout"}, bus.cfg_dout, m_cfg[CH-1]);
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check("q_pre", bus.q, model_q());
    @(posedge clk);
    model_edge();
    #1;
    check_all("post");
    @(negedge clk);
  endtask

  task automatic do_clr();
    #1 clr = 1'b1;
    #1;
    model_reset();
    check_all("clr");
    #1 clr = 1'b0;
  endtask

  task automatic set_sel(input logic a1, input logic b1, input logic a0, input logic s_en);
    bus.a1 = a1; bus.b1 = b1; bus.a0 = a0; bus.s_en = s_en;
  endtask

  task automatic rand_data();
    bus.d00 = W'($urandom); bus.d01 = W'($urandom);
    bus.d10 = W'($urandom); bus.d11 = W'($urandom);
    set_sel(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic shift_bit(input logic b);
    bus.cfg_en  = 1'b1;
    bus.cfg_din = b;
    tick();
    bus.cfg_en  = 1'b0;
  endtask

  logic [3:0]   sel_tab [6];
  logic [W-1:0] sel_exp [6];
  logic [CH-1:0] load_seq;

  initial begin
    sel_tab = '{4'b0000, 4'b0011, 4'b1000, 4'b0111, 4'b0010, 4'b1010};
    sel_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
    load_seq = 8'b1000_0001;

    clr = 1'b0;
    bus.d00 = '0; bus.d01 = '0; bus.d10 = '0; bus.d11 = '0;
    set_sel(1'b0, 1'b0, 1'b0, 1'b0);
    bus.ce = 1'b0; bus.cfg_en = 1'b0; bus.cfg_din = 1'b0;
    model_reset();
    #2 clr = 1'b1;
    #1;
    check_all("rst");
    @(negedge clk);
    clr = 1'b0;

    // Select sweep through every code, including a0 gated off by s_en.
    bus.d00 = 4'b0001; bus.d01 = 4'b0010; bus.d10 = 4'b0100; bus.d11 = 4'b1000;
    bus.ce = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_sel(sel_tab[k][3], sel_tab[k][2], sel_tab[k][1], sel_tab[k][0]);
      tick();
      check("sel_sweep", bus.q, sel_exp[k]);
    end

    // Async clear mid-operation, no clock edge needed.
    do_clr();

    // Load 1,0,0,0,0,0,0,1 while data keeps changing under ce=1.
    bus.ce = 1'b1;
    for (int k = 0; k < CH; k++) begin
      rand_data();
      shift_bit(load_seq[k]);
      check("load_busy", bus.cfg_busy, k < CH - 1);
      check("load_done", bus.cfg_done, k == CH - 1);
      if (k < CH - 1) check("load_q_zero", bus.q, '0);
    end
    check("load_dout", bus.cfg_dout, 1'b1);
    for (int k = 0; k < 6; k++) begin
      rand_data();
      bus.ce = 1'($urandom);
      tick();
    end

    // Single strobe in READY restarts the load.
    bus.ce = 1'b1;
    shift_bit(1'b0);
    check("restart_busy", bus.cfg_busy, 1'b1);
    check("restart_done", bus.cfg_done, 1'b0);
    check("restart_q",    bus.q, '0);
    check("restart_dout", bus.cfg_dout, 1'b0);
    for (int k = 1; k < CH; k++) begin
      rand_data();
      shift_bit(1'($urandom));
    end
    check("reload_done", bus.cfg_done, 1'b1);

    // Clear after 5 of 8 shifts, then a clean full load.
    for (int k = 0; k < 5; k++) begin
      rand_data();
      shift_bit(1'b1);
    end
    do_clr();
    check("midclr_dout", bus.cfg_dout, 1'b0);
    for (int k = 0; k < CH; k++) begin
      rand_data();
      shift_bit(1'($urandom));
    end
    check("after_clr_done", bus.cfg_done, 1'b1);
    check("after_clr_busy", bus.cfg_busy, 1'b0);

    // Random traffic with occasional loads and clears.
    for (int n = 0; n < 500; n++) begin
      rand_data();
      bus.ce      = 1'($urandom);
      bus.cfg_en  = ($urandom_range(0, 3) == 0);
      bus.cfg_din = 1'($urandom);
      if ($urandom_range(0, 60) == 0) do_clr();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
